// File: rtl/wm8731_pkg.sv
// Shared definitions for the WM8731 DAC I2S transmit path: frame geometry,
// mute word, bus address of the audio register and the serialiser state set.
package wm8731_pkg;

  localparam int I2S_SLOTS = 32;
  localparam int I2S_HALF  = 16;

  localparam logic [31:0] DAC_MUTE_WORD  = 32'h0000_0000;
  localparam logic [7:0]  ADDR_DAC_AUDIO = 8'h0C;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } dac_state_e;

  typedef logic [4:0] slot_t;

  // DACLRCK level for a given slot: the upper half of the frame is the right channel.
  function automatic logic slot_is_right(input slot_t slot);
    return (slot >= slot_t'(I2S_HALF));
  endfunction

endpackage

// File: rtl/wm8731_dac_i2s_tx_if.sv
// Sample write channel into the DAC transmitter: valid/ready handshake
// carrying one {left,right} stereo word per accepted cycle.
interface wm8731_dac_i2s_tx_if #(
  parameter int DATA_W = 32
);
  logic [DATA_W-1:0] wr_data;
  logic              wr_valid;
  logic              wr_ready;

  modport master (output wr_data, output wr_valid, input  wr_ready);
  modport slave  (input  wr_data, input  wr_valid, output wr_ready);
endinterface

// File: rtl/wm8731_sync_fifo.sv
// Single-clock sample FIFO. Level, full and empty are held in registers so the
// handshake and the serialiser both see glitch-free flags. Push while full and
// pop while empty are ignored, so callers may drive them unconditionally.
module wm8731_sync_fifo #(
  parameter  int DATA_W = 32,
  parameter  int DEPTH  = 4,
  localparam int AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int LW     = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] wr_data,
  output logic [DATA_W-1:0] rd_data,
  output logic [LW-1:0]     level,
  output logic              full,
  output logic              empty
);

  logic [DATA_W-1:0] mem_r [DEPTH];
  logic [AW-1:0]     wr_ptr_r;
  logic [AW-1:0]     rd_ptr_r;
  logic [LW-1:0]     level_r;
  logic [LW-1:0]     level_nxt_s;
  logic              full_r;
  logic              empty_r;
  logic              push_ok_s;
  logic              pop_ok_s;

  assign push_ok_s = push & ~full_r;
  assign pop_ok_s  = pop & ~empty_r;

  // Occupancy after this cycle's push/pop; both together leave it unchanged.
  always_comb begin
    level_nxt_s = level_r;
    case ({push_ok_s, pop_ok_s})
      2'b10:   level_nxt_s = level_r + LW'(1);
      2'b01:   level_nxt_s = level_r - LW'(1);
      default: level_nxt_s = level_r;
    endcase
  end

  // Pointers wrap modulo DEPTH (power of two); flags derive from the next level.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      level_r  <= {LW{1'b0}};
      full_r   <= 1'b0;
      empty_r  <= 1'b1;
    end else begin
      if (push_ok_s) wr_ptr_r <= wr_ptr_r + AW'(1);
      if (pop_ok_s)  rd_ptr_r <= rd_ptr_r + AW'(1);
      level_r <= level_nxt_s;
      full_r  <= (level_nxt_s == LW'(DEPTH));
      empty_r <= (level_nxt_s == {LW{1'b0}});
    end
  end

  // Storage array; contents need no reset because the pointers define validity.
  always_ff @(posedge clk) begin
    if (push_ok_s) mem_r[wr_ptr_r] <= wr_data;
  end

  assign rd_data = mem_r[rd_ptr_r];
  assign level   = level_r;
  assign full    = full_r;
  assign empty   = empty_r;

endmodule

// File: rtl/wm8731_dac_i2s_tx.sv
// I2S master transmitter for the WM8731 DAC. Buffers {L,R} words in a small
// FIFO, generates BCLK/DACLRCK from clk and shifts each word out MSB first with
// the standard one-BCLK I2S delay. LRCK and DATA only move on BCLK falling edges.
// Optional feature: define WM8731_DAC_UNDERRUN_CNT_EN to add a saturating
// 16-bit underrun_cnt output. DATA_W must stay 32 (two 16-bit channels).
module wm8731_dac_i2s_tx
  import wm8731_pkg::*;
#(
  parameter  int BCLK_DIV   = 16,
  parameter  int FIFO_DEPTH = 4,
  parameter  int DATA_W     = 32,
  localparam int LVL_W      = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  wm8731_dac_i2s_tx_if.slave   wr,
  input  logic                 enable,
  output logic                 dac_bclk,
  output logic                 dac_lrck,
  output logic                 dac_dat,
  output logic [LVL_W-1:0]     fifo_level,
  output logic                 underrun
`ifdef WM8731_DAC_UNDERRUN_CNT_EN
  ,
  output logic [15:0]          underrun_cnt
`endif
);

  localparam int CNT_W = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;

  dac_state_e        state_r;
  dac_state_e        state_nxt_s;
  logic [CNT_W-1:0]  cnt_r;
  logic              bclk_r;
  logic              lrck_r;
  logic              dat_r;
  logic              underrun_r;
  slot_t             slot_r;
  logic [DATA_W-1:0] word_r;

  logic [DATA_W-1:0] fifo_rd_data_s;
  logic              fifo_full_s;
  logic              fifo_empty_s;

  logic              active_s;
  logic              wrap_s;
  logic              fall_s;
  logic              load_s;
  logic              shift_s;
  logic              clear_s;
  logic              lrck_nxt_s;
  logic              dat_nxt_s;
  logic              underrun_nxt_s;

  wm8731_sync_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push    (wr.wr_valid),
    .pop     (load_s),
    .wr_data (wr.wr_data),
    .rd_data (fifo_rd_data_s),
    .level   (fifo_level),
    .full    (fifo_full_s),
    .empty   (fifo_empty_s)
  );

  assign wr.wr_ready = ~fifo_full_s;

  assign active_s = (state_r == ST_RUN) || (state_r == ST_DRAIN);
  assign wrap_s   = (cnt_r == CNT_W'(BCLK_DIV - 1));
  assign fall_s   = active_s & wrap_s & bclk_r;

  // BCLK divider: free-runs only while serialising, parked low when idle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_r  <= {CNT_W{1'b0}};
      bclk_r <= 1'b0;
    end else if (!active_s) begin
      cnt_r  <= {CNT_W{1'b0}};
      bclk_r <= 1'b0;
    end else if (wrap_s) begin
      cnt_r  <= {CNT_W{1'b0}};
      bclk_r <= ~bclk_r;
    end else begin
      cnt_r  <= cnt_r + CNT_W'(1);
    end
  end

  // Slot counter: holds the slot handled at the next BCLK falling edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      slot_r <= 5'd0;
    end else if (!active_s || clear_s) begin
      slot_r <= 5'd0;
    end else if (fall_s) begin
      slot_r <= slot_r + 5'd1;
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next state: enable is only honoured at frame boundaries (slot 31).
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (enable) state_nxt_s = ST_RUN;
        else        state_nxt_s = ST_IDLE;
      end
      ST_RUN: begin
        if (fall_s && (slot_r == 5'd31) && !enable) state_nxt_s = ST_DRAIN;
        else                                        state_nxt_s = ST_RUN;
      end
      ST_DRAIN: begin
        if (fall_s && (slot_r == 5'd1)) state_nxt_s = ST_IDLE;
        else                            state_nxt_s = ST_DRAIN;
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // FSM outputs: per-falling-edge pin values and shift-register control.
  always_comb begin
    load_s         = 1'b0;
    shift_s        = 1'b0;
    clear_s        = 1'b0;
    lrck_nxt_s     = lrck_r;
    dat_nxt_s      = dat_r;
    underrun_nxt_s = 1'b0;
    case (state_r)
      ST_RUN: begin
        if (!fall_s) begin
          lrck_nxt_s = lrck_r;
        end else if (slot_r == 5'd0) begin
          // Frame start: previous word's LSB goes out while the next word loads.
          lrck_nxt_s     = 1'b0;
          dat_nxt_s      = word_r[DATA_W-1];
          load_s         = 1'b1;
          underrun_nxt_s = fifo_empty_s;
        end else begin
          lrck_nxt_s = slot_is_right(slot_r);
          dat_nxt_s  = word_r[DATA_W-1];
          shift_s    = 1'b1;
        end
      end
      ST_DRAIN: begin
        if (!fall_s) begin
          lrck_nxt_s = lrck_r;
        end else if (slot_r == 5'd0) begin
          // Trailing slot carries the last word's LSB; nothing is popped.
          lrck_nxt_s = 1'b0;
          dat_nxt_s  = word_r[DATA_W-1];
        end else begin
          lrck_nxt_s = 1'b1;
          dat_nxt_s  = 1'b0;
          clear_s    = 1'b1;
        end
      end
      ST_IDLE: begin
        lrck_nxt_s = lrck_r;
      end
      default: begin
        lrck_nxt_s = 1'b1;
        dat_nxt_s  = 1'b0;
        clear_s    = 1'b1;
      end
    endcase
  end

  // Pin registers and shift register; cleared word makes the next first frame start with 0.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lrck_r     <= 1'b1;
      dat_r      <= 1'b0;
      underrun_r <= 1'b0;
      word_r     <= DATA_W'(DAC_MUTE_WORD);
    end else begin
      lrck_r     <= lrck_nxt_s;
      dat_r      <= dat_nxt_s;
      underrun_r <= underrun_nxt_s;
      if (load_s) begin
        word_r <= fifo_empty_s ? DATA_W'(DAC_MUTE_WORD) : fifo_rd_data_s;
      end else if (shift_s) begin
        word_r <= {word_r[DATA_W-2:0], 1'b0};
      end else if (clear_s) begin
        word_r <= DATA_W'(DAC_MUTE_WORD);
      end
    end
  end

  assign dac_bclk = bclk_r;
  assign dac_lrck = lrck_r;
  assign dac_dat  = dat_r;
  assign underrun = underrun_r;

`ifdef WM8731_DAC_UNDERRUN_CNT_EN
  logic [15:0] underrun_cnt_r;

  // Saturating count of underrun events since reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      underrun_cnt_r <= 16'h0000;
    end else if (underrun_nxt_s && (underrun_cnt_r != 16'hFFFF)) begin
      underrun_cnt_r <= underrun_cnt_r + 16'h0001;
    end
  end

  assign underrun_cnt = underrun_cnt_r;
`endif

endmodule

// File: tb/tb_wm8731_dac_i2s_tx.sv
// Bench for wm8731_dac_i2s_tx: directed sessions plus random ones, checked
// every clk against a slot/frame-level reference (word queue + frame arithmetic).
module tb_wm8731_dac_i2s_tx;
  import wm8731_pkg::*;

  localparam int BCLK_DIV   = 16;
  localparam int FIFO_DEPTH = 4;
  localparam int DATA_W     = 32;
  localparam int LVL_W      = $clog2(FIFO_DEPTH) + 1;
  localparam int HALF       = BCLK_DIV;
  localparam int SLOT       = 2 * BCLK_DIV;
  localparam int FRAME      = 32 * SLOT;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             enable = 1'b0;
  logic             dac_bclk;
  logic             dac_lrck;
  logic             dac_dat;
  logic             underrun;
  logic [LVL_W-1:0] fifo_level;
`ifdef WM8731_DAC_UNDERRUN_CNT_EN
  logic [15:0]      underrun_cnt;
`endif

  wm8731_dac_i2s_tx_if #(.DATA_W(DATA_W)) wr_if ();

  wm8731_dac_i2s_tx #(
    .BCLK_DIV   (BCLK_DIV),
    .FIFO_DEPTH (FIFO_DEPTH),
    .DATA_W     (DATA_W)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .wr         (wr_if),
    .enable     (enable),
    .dac_bclk   (dac_bclk),
    .dac_lrck   (dac_lrck),
    .dac_dat    (dac_dat),
    .fifo_level (fifo_level),
    .underrun   (underrun)
`ifdef WM8731_DAC_UNDERRUN_CNT_EN
    ,
    .underrun_cnt (underrun_cnt)
`endif
  );

  always #10 clk = ~clk;

  typedef enum int {M_IDLE, M_WAIT, M_RUN, M_DRAIN} mmode_t;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] m_q[$];
  logic [31:0] tx_pend[$];
  mmode_t      mode = M_IDLE;
  int          pos = 0;
  int          wait_cnt = 0;
  int          drain_n = 0;
  int          wr_prob = 1000;
  int          m_ucnt = 0;
  logic [31:0] cur_word = 32'h0;
  bit          first_frame = 1'b1;
  logic        exp_lrck = 1'b1;
  logic        exp_dat = 1'b0;
  logic        exp_under = 1'b0;
  logic        prev_bclk = 1'b0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic check_reset_state(input string tag);
    check_val({tag, "_bclk"}, 32'(dac_bclk), 32'd0);
    check_val({tag, "_lrck"}, 32'(dac_lrck), 32'd1);
    check_val({tag, "_dat"}, 32'(dac_dat), 32'd0);
    check_val({tag, "_wr_ready"}, 32'(wr_if.wr_ready), 32'd1);
    check_val({tag, "_level"}, 32'(fifo_level), 32'd0);
    check_val({tag, "_underrun"}, 32'(underrun), 32'd0);
`ifdef WM8731_DAC_UNDERRUN_CNT_EN
    check_val({tag, "_ucnt"}, 32'(underrun_cnt), 32'd0);
`endif
  endtask

  task automatic do_reset(input int ncyc);
    rst_n = 1'b0;
    enable = 1'b0;
    wr_if.wr_valid = 1'b0;
    @(posedge clk); #1;
    m_q.delete();
    mode = M_IDLE;
    exp_lrck = 1'b1;
    exp_dat = 1'b0;
    m_ucnt = 0;
    check_reset_state("rst_first_clk");
    repeat (ncyc - 1) @(posedge clk);
    #1;
    check_reset_state("rst_held");
    rst_n = 1'b1;
    prev_bclk = dac_bclk;
  endtask

  // One clock: drive, advance, update the reference, compare every output.
  task automatic cycle(input bit en_in);
    bit          ready_m;
    bit          empty_b;
    bit          push;
    logic [31:0] wd;
    int          s;
    int          k;
    ready_m = (m_q.size() < FIFO_DEPTH);
    check_val("wr_ready", 32'(wr_if.wr_ready), 32'(ready_m));
    wd = (tx_pend.size() > 0) ? tx_pend[0] : 32'h0;
    wr_if.wr_data  = wd;
    wr_if.wr_valid = (tx_pend.size() > 0) && ($urandom_range(999) < wr_prob);
    enable = en_in;
    push = wr_if.wr_valid && ready_m;
    empty_b = (m_q.size() == 0);
    @(posedge clk); #1;
    if (push) begin
      m_q.push_back(wd);
      void'(tx_pend.pop_front());
    end
    exp_under = 1'b0;
    if (mode == M_WAIT) begin
      wait_cnt++;
      if (prev_bclk && !dac_bclk) begin
        mode = M_RUN;
        pos = 0;
      end else if (wait_cnt > 2 * SLOT) begin
        check_val("first_fall_wait", wait_cnt, 2 * SLOT);
        do_reset(2);
        return;
      end
    end else if (mode == M_RUN || mode == M_DRAIN) begin
      pos++;
    end
    if ((mode == M_RUN || mode == M_DRAIN) && (pos % SLOT == 0)) begin
      s = pos / SLOT;
      k = s % 32;
      if (mode == M_RUN) begin
        if (k == 0) begin
          exp_lrck = 1'b0;
          exp_dat = first_frame ? 1'b0 : cur_word[0];
          first_frame = 1'b0;
          if (empty_b) begin
            cur_word = 32'h0;
            exp_under = 1'b1;
            if (m_ucnt < 65535) m_ucnt++;
          end else begin
            cur_word = m_q.pop_front();
          end
        end else begin
          exp_lrck = (k >= 16);
          exp_dat = cur_word[32 - k];
          if (k == 31 && !en_in) mode = M_DRAIN;
        end
      end else if (drain_n == 0) begin
        exp_lrck = 1'b0;
        exp_dat = cur_word[0];
        drain_n = 1;
      end else begin
        exp_lrck = 1'b1;
        exp_dat = 1'b0;
        mode = M_IDLE;
      end
    end
    check_val("lrck", 32'(dac_lrck), 32'(exp_lrck));
    check_val("dat", 32'(dac_dat), 32'(exp_dat));
    check_val("underrun", 32'(underrun), 32'(exp_under));
    check_val("fifo_level", 32'(fifo_level), m_q.size());
    if (mode == M_RUN || mode == M_DRAIN) begin
      check_val("bclk", 32'(dac_bclk), 32'((pos % SLOT) >= HALF));
    end else if (mode == M_IDLE) begin
      check_val("bclk_idle", 32'(dac_bclk), 32'd0);
    end
`ifdef WM8731_DAC_UNDERRUN_CNT_EN
    check_val("underrun_cnt", 32'(underrun_cnt), m_ucnt);
`endif
    prev_bclk = dac_bclk;
  endtask

  // Idle prefill, then enable; enable drops at drop_slot of the last frame.
  task automatic session(input int n_frames, input int drop_slot, input int pre_cycles,
                         input int rst_pos);
    int drop_pos;
    int guard;
    bit en;
    drop_pos = (n_frames - 1) * FRAME + drop_slot * SLOT;
    guard = 0;
    repeat (pre_cycles) cycle(1'b0);
    mode = M_WAIT;
    wait_cnt = 0;
    first_frame = 1'b1;
    drain_n = 0;
    while (mode != M_IDLE) begin
      if (mode == M_WAIT)     en = 1'b1;
      else if (mode == M_RUN) en = (pos + 1 < drop_pos);
      else                    en = 1'b0;
      cycle(en);
      guard++;
      if (rst_pos >= 0 && mode == M_RUN && pos == rst_pos) begin
        do_reset(4);
        break;
      end
      if (guard > (n_frames + 2) * FRAME) begin
        check_val("session_guard", guard, (n_frames + 2) * FRAME);
        do_reset(2);
        break;
      end
    end
    repeat (40) cycle(1'b0);
  endtask

  initial begin
    wr_if.wr_valid = 1'b0;
    wr_if.wr_data  = 32'h0;
    do_reset(10);

    // Single known word, one frame.
    wr_prob = 1000;
    tx_pend.push_back(32'h2484_2129);
    session(1, 20, 5, -1);

    // Burst of six: FIFO fills, the rest go in after each frame-start pop.
    for (int i = 0; i < 6; i++) tx_pend.push_back(32'h2484_2124 + 32'(i));
    session(6, 20, 10, -1);

    // One word, three frames: two underrun frames.
    tx_pend.push_back($urandom);
    session(3, 20, 5, -1);
`ifdef WM8731_DAC_UNDERRUN_CNT_EN
    check_val("underrun_cnt_case4", 32'(underrun_cnt), 32'd2);
`endif

    // Reset in the middle of a frame with three words still buffered.
    for (int i = 0; i < 4; i++) tx_pend.push_back($urandom);
    session(2, 20, 8, 10 * SLOT + 5);
    check_val("level_after_rst", 32'(fifo_level), 32'd0);

    // Restart straight after reset: mute frame with underrun.
    session(1, 15, 3, -1);

    // Random traffic.
    for (int r = 0; r < 4; r++) begin
      int nw;
      nw = $urandom_range(6);
      for (int i = 0; i < nw; i++) tx_pend.push_back($urandom);
      wr_prob = $urandom_range(3);
      session($urandom_range(3, 1), $urandom_range(30, 1), $urandom_range(20, 1), -1);
    end
    tx_pend.delete();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
